// File: rtl/readout_pkg.sv
// Shared types for the discriminator hit counter and its readout port.
// Default widths, frame record layout and readout FSM states.
package readout_pkg;

    localparam int CNT_W_DEF  = 16;
    localparam int TOT_W_DEF  = 20;
    localparam int SYNC_N_DEF = 2;

    typedef struct packed {
        logic [CNT_W_DEF-1:0] local_cnt;
        logic [CNT_W_DEF-1:0] sum_cnt;
        logic [TOT_W_DEF-1:0] tot;
        logic                 overrun;
    } frame_rec_t;

    typedef enum logic {
        RD_EMPTY = 1'b0,
        RD_FULL  = 1'b1
    } rd_state_t;

endpackage

// File: rtl/disc_sync_edge.sv
// Multi-flop synchronizer for one async discriminator line,
// followed by a rising-edge detector on the synced level.
module disc_sync_edge #(
    parameter int SYNC_N = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_N-1:0] sync_q;
    logic              prev_q;

    // Shift the async line through the sync chain; remember last level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], async_i};
            prev_q <= sync_q[SYNC_N-1];
        end
    end

    assign level_o = sync_q[SYNC_N-1];
    assign rise_o  = level_o & ~prev_q;

endmodule

// File: rtl/disc_hit_counter.sv
// Per-frame hit and ToT counters for the local and summing discriminators,
// with a one-deep frame record handed out over a valid/ready port.
module disc_hit_counter
    import readout_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TOT_W  = TOT_W_DEF,
    parameter int SYNC_N = SYNC_N_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             discOutLocal,
    input  logic             discOutSum,
    input  logic             frame_latch,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [CNT_W-1:0] rd_local_cnt,
    output logic [CNT_W-1:0] rd_sum_cnt,
    output logic [TOT_W-1:0] rd_tot,
    output logic             rd_overrun
);

    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    logic loc_level, loc_rise;
    logic sum_rise;
    logic sum_level_unused;

    logic [CNT_W-1:0] loc_live_q, loc_live_d, loc_inc;
    logic [CNT_W-1:0] sum_live_q, sum_live_d, sum_inc;
    logic [TOT_W-1:0] tot_live_q, tot_live_d, tot_inc;

    logic [CNT_W-1:0] loc_shd_q, loc_shd_d;
    logic [CNT_W-1:0] sum_shd_q, sum_shd_d;
    logic [TOT_W-1:0] tot_shd_q, tot_shd_d;
    logic             ovr_q, ovr_d;
    rd_state_t        state_q, state_d;

    logic load, drop, accept;

    // Reset asserts immediately, releases two clocks after reset_n rises.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    disc_sync_edge #(.SYNC_N(SYNC_N)) u_sync_loc (
        .clk_i   (clock),
        .rst_ni  (rst_n_int),
        .async_i (discOutLocal),
        .level_o (loc_level),
        .rise_o  (loc_rise)
    );

    disc_sync_edge #(.SYNC_N(SYNC_N)) u_sync_sum (
        .clk_i   (clock),
        .rst_ni  (rst_n_int),
        .async_i (discOutSum),
        .level_o (sum_level_unused),
        .rise_o  (sum_rise)
    );

    // Saturating live counts including this cycle's event; cleared on latch.
    always_comb begin
        loc_inc = loc_live_q;
        sum_inc = sum_live_q;
        tot_inc = tot_live_q;
        if (enable && loc_rise && !(&loc_live_q)) loc_inc = loc_live_q + 1'b1;
        if (enable && sum_rise && !(&sum_live_q)) sum_inc = sum_live_q + 1'b1;
        if (enable && loc_level && !(&tot_live_q)) tot_inc = tot_live_q + 1'b1;
        loc_live_d = frame_latch ? '0 : loc_inc;
        sum_live_d = frame_latch ? '0 : sum_inc;
        tot_live_d = frame_latch ? '0 : tot_inc;
    end

    // Readout FSM: keep the oldest record when the consumer stalls.
    always_comb begin
        state_d   = state_q;
        loc_shd_d = loc_shd_q;
        sum_shd_d = sum_shd_q;
        tot_shd_d = tot_shd_q;
        load      = 1'b0;
        drop      = 1'b0;
        accept    = (state_q == RD_FULL) && rd_ready;
        unique case (state_q)
            RD_EMPTY: begin
                if (frame_latch) begin
                    load    = 1'b1;
                    state_d = RD_FULL;
                end
            end
            RD_FULL: begin
                if (frame_latch && rd_ready) load = 1'b1;
                else if (frame_latch) drop = 1'b1;
                else if (rd_ready) state_d = RD_EMPTY;
            end
        endcase
        if (load) begin
            loc_shd_d = loc_inc;
            sum_shd_d = sum_inc;
            tot_shd_d = tot_inc;
        end
        ovr_d = (ovr_q && !accept) || drop;
    end

    // Live counters, shadow record and FSM state.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            loc_live_q <= '0;
            sum_live_q <= '0;
            tot_live_q <= '0;
            loc_shd_q  <= '0;
            sum_shd_q  <= '0;
            tot_shd_q  <= '0;
            ovr_q      <= 1'b0;
            state_q    <= RD_EMPTY;
        end else begin
            loc_live_q <= loc_live_d;
            sum_live_q <= sum_live_d;
            tot_live_q <= tot_live_d;
            loc_shd_q  <= loc_shd_d;
            sum_shd_q  <= sum_shd_d;
            tot_shd_q  <= tot_shd_d;
            ovr_q      <= ovr_d;
            state_q    <= state_d;
        end
    end

    assign rd_valid     = (state_q == RD_FULL);
    assign rd_local_cnt = loc_shd_q;
    assign rd_sum_cnt   = sum_shd_q;
    assign rd_tot       = tot_shd_q;
    assign rd_overrun   = ovr_q;

endmodule

// File: tb/tb_disc_hit_counter.sv
// Directed bench for disc_hit_counter: frame table plus corner sequences.
// A second instance with narrow counters exercises saturation.
module tb_disc_hit_counter;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic enable = 1'b0;
    logic discOutLocal = 1'b0;
    logic discOutSum = 1'b0;
    logic frame_latch = 1'b0;
    logic rd_ready = 1'b0;

    logic        rd_valid;
    logic [15:0] rd_local_cnt;
    logic [15:0] rd_sum_cnt;
    logic [19:0] rd_tot;
    logic        rd_overrun;

    logic       s_valid;
    logic [3:0] s_local;
    logic [3:0] s_sum;
    logic [5:0] s_tot;
    logic       s_ovr;

    int n_chk = 0;
    int n_fail = 0;

    disc_hit_counter dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .discOutLocal (discOutLocal),
        .discOutSum   (discOutSum),
        .frame_latch  (frame_latch),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .rd_local_cnt (rd_local_cnt),
        .rd_sum_cnt   (rd_sum_cnt),
        .rd_tot       (rd_tot),
        .rd_overrun   (rd_overrun)
    );

    disc_hit_counter #(.CNT_W(4), .TOT_W(6), .SYNC_N(2)) dut_small (
        .clock        (clock),
        .reset_n      (reset_n),
        .enable       (enable),
        .discOutLocal (discOutLocal),
        .discOutSum   (discOutSum),
        .frame_latch  (frame_latch),
        .rd_valid     (s_valid),
        .rd_ready     (rd_ready),
        .rd_local_cnt (s_local),
        .rd_sum_cnt   (s_sum),
        .rd_tot       (s_tot),
        .rd_overrun   (s_ovr)
    );

    always #5 clock = ~clock;

    typedef struct {
        int nl;
        int hi;
        int lo;
        int ns;
        int el;
        int es;
        int et;
        int esl;
        int est;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input int act, input int exp);
        n_chk++;
        if (act > exp + 1 || act + 1 < exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d +-1", nm, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulses_l(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            discOutLocal = 1'b1;
            cyc(hi);
            discOutLocal = 1'b0;
            cyc(lo);
        end
    endtask

    task automatic pulses_s(input int n, input int hi, input int lo);
        for (int i = 0; i < n; i++) begin
            discOutSum = 1'b1;
            cyc(hi);
            discOutSum = 1'b0;
            cyc(lo);
        end
    endtask

    task automatic latch();
        frame_latch = 1'b1;
        cyc(1);
        frame_latch = 1'b0;
    endtask

    task automatic chk_rec(input string tag, input logic v, input int l,
                           input int s, input int t, input logic o);
        chk({tag, ".valid"}, 32'(rd_valid), 32'(v));
        chk({tag, ".local"}, 32'(rd_local_cnt), l);
        chk({tag, ".sum"}, 32'(rd_sum_cnt), s);
        chk({tag, ".tot"}, 32'(rd_tot), t);
        chk({tag, ".ovr"}, 32'(rd_overrun), 32'(o));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{nl: 10, hi: 5, lo: 5, ns: 3, el: 10, es: 3, et: 50,
                   esl: 10, est: 50};
        tbl[1] = '{nl: 0, hi: 1, lo: 1, ns: 0, el: 0, es: 0, et: 0,
                   esl: 0, est: 0};
        tbl[2] = '{nl: 4, hi: 1, lo: 1, ns: 2, el: 4, es: 2, et: 4,
                   esl: 4, est: 4};
        tbl[3] = '{nl: 3, hi: 7, lo: 2, ns: 0, el: 3, es: 0, et: 21,
                   esl: 3, est: 21};
        tbl[4] = '{nl: 20, hi: 4, lo: 1, ns: 1, el: 20, es: 1, et: 80,
                   esl: 15, est: 63};

        #12;
        chk_rec("reset", 1'b0, 0, 0, 0, 1'b0);
        chk("reset.small_valid", 32'(s_valid), 0);
        cyc(1);
        reset_n = 1'b1;
        cyc(3);
        enable = 1'b1;
        rd_ready = 1'b1;

        for (int k = 0; k < 5; k++) begin
            pulses_l(tbl[k].nl, tbl[k].hi, tbl[k].lo);
            pulses_s(tbl[k].ns, tbl[k].hi, tbl[k].lo);
            cyc(4);
            latch();
            chk_rec($sformatf("tbl%0d", k), 1'b1, tbl[k].el, tbl[k].es,
                    tbl[k].et, 1'b0);
            chk($sformatf("tbl%0d.small_local", k), 32'(s_local),
                tbl[k].esl);
            chk($sformatf("tbl%0d.small_tot", k), 32'(s_tot), tbl[k].est);
            cyc(1);
            chk($sformatf("tbl%0d.valid_after", k), 32'(rd_valid), 0);
        end

        discOutLocal = 1'b1;
        cyc(2);
        frame_latch = 1'b1;
        cyc(1);
        frame_latch = 1'b0;
        discOutLocal = 1'b0;
        chk_rec("edge_on_latch", 1'b1, 1, 0, 1, 1'b0);
        cyc(2);
        discOutLocal = 1'b1;
        cyc(1);
        frame_latch = 1'b1;
        cyc(1);
        frame_latch = 1'b0;
        discOutLocal = 1'b0;
        chk_rec("edge_after_latch_a", 1'b1, 0, 0, 2, 1'b0);
        cyc(4);
        latch();
        chk_rec("edge_after_latch_b", 1'b1, 1, 0, 2, 1'b0);
        cyc(1);

        rd_ready = 1'b0;
        pulses_l(4, 2, 2);
        cyc(4);
        latch();
        chk_rec("stall_f1", 1'b1, 4, 0, 8, 1'b0);
        pulses_l(7, 2, 2);
        cyc(4);
        latch();
        chk_rec("stall_f2", 1'b1, 4, 0, 8, 1'b1);
        pulses_l(2, 2, 2);
        cyc(4);
        latch();
        chk_rec("stall_f3", 1'b1, 4, 0, 8, 1'b1);
        rd_ready = 1'b1;
        cyc(1);
        chk("stall_accept.valid", 32'(rd_valid), 0);
        chk("stall_accept.ovr", 32'(rd_overrun), 0);
        pulses_l(2, 2, 2);
        cyc(4);
        latch();
        chk_rec("after_stall", 1'b1, 2, 0, 4, 1'b0);
        rd_ready = 1'b0;
        cyc(1);
        pulses_l(3, 1, 1);
        cyc(4);
        frame_latch = 1'b1;
        rd_ready = 1'b1;
        cyc(1);
        frame_latch = 1'b0;
        chk_rec("back_to_back", 1'b1, 3, 0, 3, 1'b0);
        cyc(1);
        chk("back_to_back.valid_after", 32'(rd_valid), 0);

        cyc(100);
        latch();
        chk_rec("duty0", 1'b1, 0, 0, 0, 1'b0);
        discOutLocal = 1'b1;
        cyc(100);
        discOutLocal = 1'b0;
        cyc(4);
        latch();
        chk("duty100.local", 32'(rd_local_cnt), 1);
        chk_tol("duty100.tot", int'(rd_tot), 100);
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            discOutLocal = 1'b1;
            repeat (5) @(negedge clock);
            discOutLocal = 1'b0;
            repeat (5) @(negedge clock);
        end
        cyc(4);
        latch();
        chk("duty50.local", 32'(rd_local_cnt), 10);
        chk_tol("duty50.tot", int'(rd_tot), 50);
        cyc(1);

        rd_ready = 1'b0;
        pulses_l(3, 2, 2);
        cyc(4);
        latch();
        pulses_l(2, 2, 2);
        cyc(4);
        latch();
        chk_rec("pre_reset", 1'b1, 3, 0, 6, 1'b1);
        pulses_l(2, 2, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk_rec("async_reset", 1'b0, 0, 0, 0, 1'b0);
        frame_latch = 1'b1;
        cyc(2);
        frame_latch = 1'b0;
        chk("reset_latch_ignored", 32'(rd_valid), 0);
        reset_n = 1'b1;
        cyc(3);
        chk("post_reset.valid", 32'(rd_valid), 0);
        rd_ready = 1'b1;
        pulses_l(2, 3, 2);
        enable = 1'b0;
        pulses_l(3, 3, 2);
        cyc(4);
        enable = 1'b1;
        cyc(1);
        latch();
        chk_rec("post_reset_frame", 1'b1, 2, 0, 6, 1'b0);
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
